// File: rtl/link_fib_gen.sv
// link_fib_gen: emits len Fibonacci terms (mod 2^WIDTH) as dual-rail tokens.
// ENC="TP" gives two-phase (transition) signalling; ENC="FP" gives four-phase
// return-to-zero signalling with an all-zero spacer after every token.
// Optional macro FIB_ACK_SYNC_EN: route out_ack through a two-flop synchronizer
// before the FSM. Without it, out_ack is used directly.
module link_fib_gen #(
   parameter int    WIDTH = 8,
   parameter int    LEN_W = 8,
   parameter string ENC   = "TP"
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   output logic [WIDTH-1:0] out_d0,
   output logic [WIDTH-1:0] out_d1,
   input  logic             out_ack,
   output logic             busy,
   output logic             done,
   output logic             ovf
);

   localparam bit IS_FP = (ENC == "FP");

   typedef enum logic [2:0] {
      S_IDLE, S_DRIVE, S_WAIT_ACK, S_RTZ, S_WAIT_RTZ, S_NEXT
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;     // a = term to emit, b = following term
   logic             ac_q, ac_d, bc_q, bc_d; // carry-out that produced a / b
   logic [LEN_W-1:0] cnt_q, cnt_d;           // terms still to emit, including a
   logic             ph_q, ph_d;             // last ack phase consumed (TP)
   logic             done_q, done_d, ovf_q, ovf_d;
   logic             ack_obs;

`ifdef FIB_ACK_SYNC_EN
   logic ack_s1_q, ack_s2_q;
   // Two-flop synchronizer: receiver may run on an unrelated clock
   always_ff @(posedge clk) begin
      if (rst) begin
         ack_s1_q <= 1'b0;
         ack_s2_q <= 1'b0;
      end else begin
         ack_s1_q <= out_ack;
         ack_s2_q <= ack_s1_q;
      end
   end
   assign ack_obs = ack_s2_q;
`else
   assign ack_obs = out_ack;
`endif

   // Next-state, rail and term-pair update
   always_comb begin
      state_d = state_q;
      d0_d    = d0_q;
      d1_d    = d1_q;
      a_d     = a_q;
      b_d     = b_q;
      ac_d    = ac_q;
      bc_d    = bc_q;
      cnt_d   = cnt_q;
      ph_d    = ph_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               ovf_d = 1'b0;
               a_d   = '0;
               b_d   = WIDTH'(1);
               ac_d  = 1'b0;
               bc_d  = 1'b0;
               cnt_d = len;
               if (len == '0) done_d = 1'b1;
               else           state_d = S_DRIVE;
            end
         end
         S_DRIVE: begin
            if (IS_FP) begin
               d1_d = a_q;
               d0_d = ~a_q;
            end else begin
               d1_d = d1_q ^ a_q;
               d0_d = d0_q ^ ~a_q;
            end
            // Only a term that actually goes on the link can flag overflow
            if (ac_q) ovf_d = 1'b1;
            state_d = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (IS_FP) begin
               if (ack_obs) state_d = S_RTZ;
            end else if (ack_obs != ph_q) begin
               ph_d    = ack_obs;
               state_d = S_NEXT;
            end
         end
         S_RTZ: begin
            d0_d    = '0;
            d1_d    = '0;
            state_d = S_WAIT_RTZ;
         end
         S_WAIT_RTZ: begin
            if (!ack_obs) state_d = S_NEXT;
         end
         S_NEXT: begin
            a_d          = b_q;
            ac_d         = bc_q;
            {bc_d, b_d}  = {1'b0, a_q} + {1'b0, b_q};
            cnt_d        = cnt_q - LEN_W'(1);
            if (cnt_d == '0) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = S_DRIVE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         d0_q    <= '0;
         d1_q    <= '0;
         a_q     <= '0;
         b_q     <= WIDTH'(1);
         ac_q    <= 1'b0;
         bc_q    <= 1'b0;
         cnt_q   <= '0;
         ph_q    <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         d0_q    <= d0_d;
         d1_q    <= d1_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ac_q    <= ac_d;
         bc_q    <= bc_d;
         cnt_q   <= cnt_d;
         ph_q    <= ph_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   assign out_d0 = d0_q;
   assign out_d1 = d1_q;
   assign busy   = (state_q != S_IDLE);
   assign done   = done_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_link_fib_gen.sv
// Directed bench for link_fib_gen: a TP instance and an FP instance, each
// with a behavioural receiver driven from the bench.
module tb_link_fib_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_tp = 1'b0, start_fp = 1'b0;
   logic [7:0] len = '0;
   logic       ack_tp = 1'b0, ack_fp = 1'b0;
   logic [7:0] tp_d0, tp_d1, fp_d0, fp_d1;
   logic       tp_busy, tp_done, tp_ovf, fp_busy, fp_done, fp_ovf;

   int nvec = 0;
   int nmis = 0;

   logic [7:0] fib_exp [16] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                                8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121, 8'd98};

   always #5 clk = ~clk;

   link_fib_gen #(.WIDTH(8), .LEN_W(8), .ENC("TP")) dut_tp (
      .clk(clk), .rst(rst), .start(start_tp), .len(len),
      .out_d0(tp_d0), .out_d1(tp_d1), .out_ack(ack_tp),
      .busy(tp_busy), .done(tp_done), .ovf(tp_ovf));

   link_fib_gen #(.WIDTH(8), .LEN_W(8), .ENC("FP")) dut_fp (
      .clk(clk), .rst(rst), .start(start_fp), .len(len),
      .out_d0(fp_d0), .out_d1(fp_d1), .out_ack(ack_fp),
      .busy(fp_busy), .done(fp_done), .ovf(fp_ovf));

   typedef struct {
      logic [7:0] len;
      logic [7:0] exp_last;
      logic       exp_ovf;
      bit         restart;
   } vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Run one TP sequence; receiver acks 3 cycles after each token.
   task automatic tp_seq(input logic [7:0] n, input bit restart,
                         output int ntok, output int ndone, output logic [7:0] last);
      logic [7:0] pd0, pd1, ch0, ch1;
      int cyc;
      ntok = 0; ndone = 0; last = '0; cyc = 0;
      len = n; start_tp = 1'b1; step(); start_tp = 1'b0;
      chk("tp busy after start", tp_busy, 1);
      pd0 = tp_d0; pd1 = tp_d1;
      while (ndone == 0 && cyc < 600) begin
         if (tp_done) ndone++;
         if (tp_d0 !== pd0 || tp_d1 !== pd1) begin
            ch0 = tp_d0 ^ pd0;
            ch1 = tp_d1 ^ pd1;
            chk("tp one rail per bit", ch0 ^ ch1, 8'hFF);
            chk("tp one rail per bit excl", ch0 & ch1, 8'h00);
            if (ntok < 16) chk("tp term", ch1, fib_exp[ntok]);
            last = ch1;
            ntok++;
            pd0 = tp_d0; pd1 = tp_d1;
            if (restart && ntok == 1) begin
               len = 8'd9; start_tp = 1'b1; step(); start_tp = 1'b0; len = n;
               repeat (2) step();
            end else begin
               repeat (3) step();
            end
            chk("tp rails held in wait_ack", {tp_d0, tp_d1}, {pd0, pd1});
            ack_tp = ~ack_tp;
         end
         step();
         cyc++;
      end
      chk("tp done within budget", (ndone != 0), 1);
      repeat (4) begin
         step();
         if (tp_done) ndone++;
         if (tp_d0 !== pd0 || tp_d1 !== pd1) ntok++;
      end
      chk("tp busy after end", tp_busy, 0);
   endtask

   // Wait for an FP token (want=1) or an all-zero spacer (want=0).
   task automatic fp_wait(input bit want, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (want ? ((fp_d0 | fp_d1) != 0) : ((fp_d0 | fp_d1) == 0)) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   vec_t vecs [5];
   int   ntok, ndone;
   logic [7:0] last, pd0, pd1;
   bit   ok;

   initial begin
      vecs[0] = '{len: 8'd5,  exp_last: 8'd3,   exp_ovf: 1'b0, restart: 1'b0};
      vecs[1] = '{len: 8'd15, exp_last: 8'd121, exp_ovf: 1'b1, restart: 1'b0};
      vecs[2] = '{len: 8'd14, exp_last: 8'd233, exp_ovf: 1'b0, restart: 1'b0};
      vecs[3] = '{len: 8'd1,  exp_last: 8'd0,   exp_ovf: 1'b0, restart: 1'b0};
      vecs[4] = '{len: 8'd3,  exp_last: 8'd1,   exp_ovf: 1'b0, restart: 1'b1};

      repeat (3) step();
      rst = 1'b0;
      step();
      chk("reset rails", {tp_d0, tp_d1, fp_d0, fp_d1}, 32'h0);
      chk("reset flags", {tp_busy, tp_done, tp_ovf, fp_busy, fp_done, fp_ovf}, 6'b0);

      // Table-driven TP runs
      for (int v = 0; v < 5; v++) begin
         tp_seq(vecs[v].len, vecs[v].restart, ntok, ndone, last);
         chk("tp token count", ntok, vecs[v].len);
         chk("tp single done", ndone, 1);
         chk("tp last term", last, vecs[v].exp_last);
         chk("tp ovf", tp_ovf, vecs[v].exp_ovf);
      end

      // len=0: done next cycle, busy low, rails untouched; also clears ovf
      tp_seq(8'd15, 1'b0, ntok, ndone, last);
      chk("ovf set before len0", tp_ovf, 1);
      pd0 = tp_d0; pd1 = tp_d1;
      len = 8'd0; start_tp = 1'b1; step(); start_tp = 1'b0;
      chk("len0 done pulse", tp_done, 1);
      chk("len0 busy", tp_busy, 0);
      chk("len0 ovf cleared", tp_ovf, 0);
      step();
      chk("len0 done one cycle", tp_done, 0);
      chk("len0 rails unchanged", {tp_d0, tp_d1}, {pd0, pd1});

      // Reset while token 2 is waiting for ack
      len = 8'd5; start_tp = 1'b1; step(); start_tp = 1'b0;
      pd0 = tp_d0; pd1 = tp_d1;
      ntok = 0;
      for (int c = 0; c < 60 && ntok < 2; c++) begin
         if (tp_d0 !== pd0 || tp_d1 !== pd1) begin
            ntok++;
            pd0 = tp_d0; pd1 = tp_d1;
            if (ntok == 1) begin
               repeat (3) step();
               ack_tp = ~ack_tp;
            end
         end
         if (ntok < 2) step();
      end
      chk("rst test reached token 2", ntok, 2);
      step();
      rst = 1'b1; ack_tp = 1'b0; step(); rst = 1'b0;
      chk("rst mid-op rails", {tp_d0, tp_d1}, 16'h0);
      chk("rst mid-op flags", {tp_busy, tp_done, tp_ovf}, 3'b0);
      step();
      tp_seq(8'd2, 1'b0, ntok, ndone, last);
      chk("post-rst token count", ntok, 2);
      chk("post-rst last term", last, 1);
      chk("post-rst single done", ndone, 1);

      // FP run, len=4: each token followed by an all-zero spacer
      len = 8'd4; start_fp = 1'b1; step(); start_fp = 1'b0;
      chk("fp busy after start", fp_busy, 1);
      for (int t = 0; t < 4; t++) begin
         fp_wait(1'b1, ok);
         chk("fp token arrives", ok, 1);
         chk("fp dual-rail", fp_d0 ^ fp_d1, 8'hFF);
         chk("fp term", fp_d1, fib_exp[t]);
         pd0 = fp_d0; pd1 = fp_d1;
         repeat (2) step();
         chk("fp hold in wait_ack", {fp_d0, fp_d1}, {pd0, pd1});
         ack_fp = 1'b1;
         fp_wait(1'b0, ok);
         chk("fp spacer", ok, 1);
         ndone = 0;
         repeat (3) begin
            step();
            if ((fp_d0 | fp_d1) != 0) ndone++;
         end
         chk("fp no token before ack low", ndone, 0);
         ack_fp = 1'b0;
      end
      ndone = 0;
      for (int c = 0; c < 20; c++) begin
         if (fp_done) ndone++;
         step();
      end
      chk("fp single done", ndone, 1);
      chk("fp idle after run", {fp_busy, fp_ovf}, 2'b0);
      chk("fp rails zero after run", {fp_d0, fp_d1}, 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
